// File: rtl/bcd_pkg.sv
// Shared constants, FSM state type and digit helpers for the 100-digit BCD serializer.
// Leading-zero suppression is selected with the BCD_LZS_EN macro in the top module.
package bcd_pkg;

  localparam int BCD_WIDTH  = 4;
  localparam int NUM_DIGITS = 100;
  localparam int SUM_WIDTH  = 400;
  localparam int BCD_MAX    = 9;
  localparam int IDX_WIDTH  = 7;

  // Beat index 100 is the decimal carry; 99..0 address the packed digits.
  localparam logic [IDX_WIDTH-1:0] CARRY_IDX = 7'd100;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } bcd_state_e;

  function automatic logic [BCD_WIDTH-1:0] bcd_digit_at(
    input logic [SUM_WIDTH-1:0] sum,
    input logic                 cout,
    input logic [IDX_WIDTH-1:0] idx
  );
    logic [BCD_WIDTH-1:0] digit;
    if (idx >= CARRY_IDX) begin
      digit = {3'b000, cout};
    end else begin
      digit = sum[{idx, 2'b00} +: BCD_WIDTH];
    end
    return digit;
  endfunction

  function automatic logic bcd_is_invalid(input logic [BCD_WIDTH-1:0] digit);
    return (digit > 4'(BCD_MAX));
  endfunction

endpackage

// File: rtl/bcd_lzc.sv
// Combinational priority encoder: index of the most significant non-zero BCD digit
// (0 when every digit is zero). Only instantiated when BCD_LZS_EN is defined.
module bcd_lzc
  import bcd_pkg::*;
(
  input  logic [SUM_WIDTH-1:0] digits,
  output logic [IDX_WIDTH-1:0] msd_idx
);

  // Ascending scan so the highest non-zero digit is the last one to win.
  always_comb begin
    msd_idx = 7'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digits[i*BCD_WIDTH +: BCD_WIDTH] != 4'd0) begin
        msd_idx = 7'(i);
      end else begin
        msd_idx = msd_idx;
      end
    end
  end

endmodule

// File: rtl/bcd_serializer_100.sv
// Captures a 100-digit BCD sum plus carry and streams it most significant digit first.
// Define BCD_LZS_EN to enable leading-zero suppression (carry beat only when cout = 1).
module bcd_serializer_100
  import bcd_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SUM_WIDTH-1:0] in_sum,
  input  logic                 in_cout,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BCD_WIDTH-1:0] out_digit,
  output logic                 out_last,
  output logic                 out_err,
  output logic                 busy
);

  bcd_state_e           state_q, state_d;
  logic [SUM_WIDTH-1:0] sum_q, sum_d;
  logic                 cout_q, cout_d;
  logic [IDX_WIDTH-1:0] idx_q, idx_d;
  logic                 valid_q, valid_d;
  logic [BCD_WIDTH-1:0] digit_q, digit_d;
  logic                 last_q, last_d;
  logic                 err_q, err_d;

  logic                 capture_s;
  logic                 accept_s;
  logic                 final_beat_s;
  logic [IDX_WIDTH-1:0] start_idx_s;
  logic [IDX_WIDTH-1:0] next_idx_s;
  logic [BCD_WIDTH-1:0] next_digit_s;

`ifdef BCD_LZS_EN
  logic [IDX_WIDTH-1:0] msd_idx_s;

  bcd_lzc u_lzc (
    .digits  (in_sum),
    .msd_idx (msd_idx_s)
  );

  assign start_idx_s = in_cout ? CARRY_IDX : msd_idx_s;
`else
  assign start_idx_s = CARRY_IDX;
`endif

  assign capture_s    = in_valid && (state_q == IDLE);
  assign accept_s     = valid_q && out_ready;
  assign final_beat_s = (idx_q == 7'd0);
  // Guarded against wrap: only used when the current index is non-zero.
  assign next_idx_s   = final_beat_s ? 7'd0 : (idx_q - 7'd1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (capture_s) begin
          state_d = SEND;
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        if (accept_s && final_beat_s) begin
          state_d = IDLE;
        end else begin
          state_d = SEND;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sum_d        = sum_q;
    cout_d       = cout_q;
    idx_d        = idx_q;
    valid_d      = valid_q;
    digit_d      = digit_q;
    last_d       = last_q;
    err_d        = err_q;
    next_digit_s = 4'd0;
    case (state_q)
      IDLE: begin
        if (capture_s) begin
          next_digit_s = bcd_digit_at(in_sum, in_cout, start_idx_s);
          sum_d        = in_sum;
          cout_d       = in_cout;
          idx_d        = start_idx_s;
          valid_d      = 1'b1;
          digit_d      = next_digit_s;
          last_d       = (start_idx_s == 7'd0);
          err_d        = bcd_is_invalid(next_digit_s);
        end else begin
          valid_d = 1'b0;
        end
      end
      SEND: begin
        if (accept_s && final_beat_s) begin
          valid_d = 1'b0;
          digit_d = 4'd0;
          last_d  = 1'b0;
          err_d   = 1'b0;
        end else if (accept_s) begin
          next_digit_s = bcd_digit_at(sum_q, cout_q, next_idx_s);
          idx_d        = next_idx_s;
          digit_d      = next_digit_s;
          last_d       = (next_idx_s == 7'd0);
          err_d        = bcd_is_invalid(next_digit_s);
        end else begin
          valid_d = valid_q;
        end
      end
      default: begin
        valid_d = 1'b0;
        last_d  = 1'b0;
        err_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q   <= '0;
      cout_q  <= 1'b0;
      idx_q   <= 7'd0;
      valid_q <= 1'b0;
      digit_q <= 4'd0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      digit_q <= digit_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == SEND);
  assign out_valid = valid_q;
  assign out_digit = digit_q;
  assign out_last  = last_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_bcd_serializer_100.sv
// Directed bench for bcd_serializer_100; expectations adapt when BCD_LZS_EN is defined.
module tb_bcd_serializer_100;
  import bcd_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [399:0] in_sum;
  logic         in_cout;
  logic         out_valid;
  logic         out_ready;
  logic [3:0]   out_digit;
  logic         out_last;
  logic         out_err;
  logic         busy;

  int n_cmp = 0;
  int n_mis = 0;

  logic [3:0] got_digit [0:127];
  logic       got_last  [0:127];
  logic       got_err   [0:127];
  logic [3:0] exp_digit [0:127];
  int         nbeats;
  int         stab_bad;
  int         timeout;
  logic       ready_after;
  logic [399:0] sum_v;

  always #5 clk = ~clk;

  bcd_serializer_100 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .in_cout   (in_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_digit (out_digit),
    .out_last  (out_last),
    .out_err   (out_err),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_exp();
    for (int k = 0; k < 128; k++) exp_digit[k] = 4'd0;
  endtask

  // Called at a falling edge while idle; returns at the falling edge of the first beat.
  task automatic start(input string tag, input logic [399:0] sum, input logic cout);
    in_sum   = sum;
    in_cout  = cout;
    in_valid = 1'b1;
    check({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_first_beat_latency"}, 32'(out_valid), 32'd1);
  endtask

  task automatic collect(input bit bp, input bit poke);
    int         cyc;
    logic       stalled;
    logic [3:0] pd;
    logic       pl;
    logic       pe;
    nbeats = 0; stab_bad = 0; timeout = 0; cyc = 0;
    stalled = 1'b0; pd = 4'd0; pl = 1'b0; pe = 1'b0;
    while (out_valid === 1'b1 && timeout == 0) begin
      out_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      if (poke) begin
        in_valid = cyc[0];
        in_sum   = {100{4'h9}};
        in_cout  = 1'b1;
      end
      if (stalled && (out_digit !== pd || out_last !== pl || out_err !== pe)) stab_bad++;
      if (out_ready) begin
        if (nbeats < 128) begin
          got_digit[nbeats] = out_digit;
          got_last[nbeats]  = out_last;
          got_err[nbeats]   = out_err;
        end
        nbeats++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        pd = out_digit; pl = out_last; pe = out_err;
      end
      @(negedge clk);
      cyc++;
      if (cyc > 500) timeout = 1;
    end
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    ready_after = in_ready;
  endtask

  task automatic verify(input string tag, input int exp_n);
    int bad_d = 0;
    int bad_l = 0;
    int bad_e = 0;
    check({tag, "_timeout"}, 32'(timeout), 32'd0);
    check({tag, "_beats"}, 32'(nbeats), 32'(exp_n));
    for (int k = 0; k < exp_n && k < nbeats && k < 128; k++) begin
      if (got_digit[k] !== exp_digit[k]) bad_d++;
      if (got_last[k] !== (k == exp_n - 1)) bad_l++;
      if (got_err[k] !== (exp_digit[k] > 4'd9)) bad_e++;
    end
    check({tag, "_digit_errs"}, 32'(bad_d), 32'd0);
    check({tag, "_last_errs"}, 32'(bad_l), 32'd0);
    check({tag, "_err_flag_errs"}, 32'(bad_e), 32'd0);
    check({tag, "_in_ready_after"}, 32'(ready_after), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sum = '0; in_cout = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_out_digit", 32'(out_digit), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Single digit 7 in the least significant position.
    clear_exp();
    start("t1", 400'h7, 1'b0);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_in_ready_send", 32'(in_ready), 32'd0);
    collect(1'b0, 1'b0);
`ifdef BCD_LZS_EN
    exp_digit[0] = 4'd7;
    verify("t1", 1);
`else
    exp_digit[100] = 4'd7;
    verify("t1", 101);
`endif
    @(negedge clk);

    // Digits 2..0 = 1, 2, 3.
    clear_exp();
    start("t2", 400'h123, 1'b0);
    collect(1'b0, 1'b0);
`ifdef BCD_LZS_EN
    exp_digit[0] = 4'd1; exp_digit[1] = 4'd2; exp_digit[2] = 4'd3;
    verify("t2", 3);
`else
    exp_digit[98] = 4'd1; exp_digit[99] = 4'd2; exp_digit[100] = 4'd3;
    verify("t2", 101);
`endif
    @(negedge clk);

    // Carry only: 1 followed by 100 zeros in both builds.
    clear_exp();
    exp_digit[0] = 4'd1;
    start("t3", '0, 1'b1);
    collect(1'b0, 1'b0);
    verify("t3", 101);
    @(negedge clk);

    // All zero, no carry.
    clear_exp();
    start("t4", '0, 1'b0);
    collect(1'b0, 1'b0);
`ifdef BCD_LZS_EN
    verify("t4", 1);
`else
    verify("t4", 101);
`endif
    @(negedge clk);

    // Backpressure 1,0,0,1 with in_valid pokes during SEND; digit i = i mod 10.
    clear_exp();
    sum_v = '0;
    for (int i = 0; i < 100; i++) sum_v[i*4 +: 4] = 4'(i % 10);
    exp_digit[0] = 4'd1;
    for (int k = 1; k <= 100; k++) exp_digit[k] = 4'((100 - k) % 10);
    start("t5", sum_v, 1'b1);
    collect(1'b1, 1'b1);
    check("t5_stall_stable", 32'(stab_bad), 32'd0);
    verify("t5", 101);
    @(negedge clk);

    // Non-BCD digit 50 = 0xC, digit 0 = 5.
    clear_exp();
    sum_v = '0;
    sum_v[50*4 +: 4] = 4'hC;
    sum_v[3:0] = 4'h5;
    start("t6", sum_v, 1'b0);
    collect(1'b0, 1'b0);
`ifdef BCD_LZS_EN
    exp_digit[0] = 4'hC; exp_digit[50] = 4'd5;
    verify("t6", 51);
`else
    exp_digit[50] = 4'hC; exp_digit[100] = 4'd5;
    verify("t6", 101);
`endif
    @(negedge clk);

    // Reset in the middle of a long transfer.
    start("t7", 400'h7, 1'b1);
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("t7_midway_valid", 32'(out_valid), 32'd1);
    check("t7_midway_last", 32'(out_last), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    check("t7_rst_out_valid", 32'(out_valid), 32'd0);
    check("t7_rst_in_ready", 32'(in_ready), 32'd1);
    check("t7_rst_out_last", 32'(out_last), 32'd0);
    check("t7_rst_busy", 32'(busy), 32'd0);
    check("t7_rst_out_digit", 32'(out_digit), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Recovery after reset.
    clear_exp();
    exp_digit[0] = 4'd1; exp_digit[98] = 4'd1; exp_digit[99] = 4'd2; exp_digit[100] = 4'd3;
    start("t8", 400'h123, 1'b1);
    collect(1'b0, 1'b0);
    verify("t8", 101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/bcd_serializer_100.md
BCD_SERIALIZER_100 -- requirements
Module: bcd_serializer_100

Interface
REQ-001 SHALL use one clock and one reset: reset is synchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous active-low reset.
REQ-004 in_valid  input  1  upstream 100-digit BCD adder result present.
REQ-005 in_ready  output  1  block can capture a result.
REQ-006 in_sum  input  400  100 packed BCD digits; digit i at bits [4i+3:4i]; digit 99 most significant.
REQ-007 in_cout  input  1  decimal carry out of the adder.
REQ-008 out_valid  output  1  out_digit valid.
REQ-009 out_ready  input  1  downstream accepts the current digit.
REQ-010 out_digit  output  4  one BCD digit, most significant first.
REQ-011 out_last  output  1  current beat is the final digit of the number.
REQ-012 out_err  output  1  current digit value is greater than 9 (not BCD).
REQ-013 busy  output  1  a number is held or being sent.

Function
REQ-014 SHALL be a two-state FSM with states IDLE and SEND.
REQ-015 SHALL drive in_ready = 1 only in IDLE.
- Capture occurs on in_valid && in_ready in cycle N.
- Capture registers in_sum and in_cout and moves to SEND.
REQ-016 SHALL assert out_valid from cycle N+1 (one-cycle latency) for as long as the state is SEND.
REQ-017 SHALL fix the digit sequence at capture as follows:
- Carry beat: value in_cout (0 or 1).
- Then digits 99 down to 0.
- Default length: 101 beats.
REQ-018 SHALL advance one beat only on out_valid && out_ready.
REQ-019 SHALL hold out_digit, out_last and out_err stable while out_valid && !out_ready.
REQ-020 SHALL set out_err = 1 only when out_digit > 9; such digits SHALL still be emitted unmodified.
REQ-021 SHALL assert out_last together with digit 0 only.
REQ-022 On acceptance of the out_last beat, SHALL return to IDLE:
- in_ready rises in the next cycle.
- No same-cycle capture (minimum 1 idle cycle between numbers).
REQ-023 SHALL ignore in_valid, and SHALL leave the held number unchanged, while in SEND.
REQ-024 SHALL use a 7-bit beat index that counts down to 0 and never wraps.
REQ-025 SHALL drive busy = (state == SEND).

Reset
REQ-026 When rst_n = 0 at a clock edge, SHALL set:
- State: IDLE.
- out_valid, out_last, out_err, busy: 0.
- out_digit: 0.
- Held sum: 0.
- Index: 0.
REQ-027 SHALL abandon any in-progress transmission on reset without emitting a partial out_last.
REQ-028 SHALL drive in_ready = 1 in the first cycle after rst_n is deasserted.

Configuration
REQ-029 Macro BCD_LZS_EN SHALL enable leading-zero suppression.
REQ-030 With BCD_LZS_EN defined:
- The carry beat is emitted only when in_cout = 1.
- If in_cout = 0, zero digits above the most significant non-zero digit are skipped.
- The start index is computed at capture.
- REQ-016 latency is unchanged.
- An all-zero value with in_cout = 0 emits exactly one beat: digit 0 with out_last = 1.
- When in_cout = 1, all 100 digits follow the carry beat.
REQ-031 Without BCD_LZS_EN, SHALL always emit 101 beats as in REQ-017; no leading-zero logic is synthesized.

Structure
REQ-032 Shared package bcd_pkg SHALL hold:
- Constants: BCD_WIDTH = 4, NUM_DIGITS = 100, SUM_WIDTH = 400, BCD_MAX = 9.
- The FSM state typedef.
REQ-033 Sub-module bcd_lzc SHALL be a combinational priority encoder.
- Function: returns the index of the most significant non-zero digit (0 if all zero).
- Instantiated only under BCD_LZS_EN.

Verification
REQ-034 Full-length, default build:
- Stimulus: in_sum = digit0 = 7, all others 0; in_cout = 0; out_ready = 1.
- Response: 101 beats (0, 99 zeros, then 7); out_last on the 7; in_ready high 1 cycle later.
REQ-035 Suppression, BCD_LZS_EN build:
- Stimulus: in_sum = 0x...0123 (digits 2..0 = 1, 2, 3); in_cout = 0.
- Response: exactly 3 beats, 1, 2, 3; out_last on 3; first beat at capture + 1.
REQ-036 Carry, BCD_LZS_EN build:
- Stimulus: in_cout = 1; in_sum all zero.
- Response: 101 beats, first = 1, then 100 zeros.
REQ-037 Backpressure:
- Stimulus: out_ready toggling 1, 0, 0, 1 every beat; new in_valid pulses during SEND.
- Response: out_digit and out_last stable during stalls; in_valid pulses ignored; sequence intact.
REQ-038 Error and reset:
- Stimulus: digit 50 = 0xC.
- Response: out_err = 1 only on that beat.
- Stimulus: rst_n = 0 mid-transfer.
- Response: next cycle out_valid = 0, in_ready = 1, no out_last.
